pulse_period_counter: RTL and testbench



---
 rtl/pulse_timer_pkg.sv | 20 ++
 rtl/period_cfg_shadow.sv | 55 +++++
 rtl/pulse_period_counter.sv | 192 +++++++++++++++++++
 tb/tb_pulse_period_counter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_timer_pkg.sv
// Shared types and default sizes for the pulse period counter and its
// configuration shadow register.
package pulse_timer_pkg;

    localparam int PT_WIDTH        = 16;
    localparam int PT_REPEAT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } pt_state_e;

    typedef struct packed {
        logic [PT_WIDTH-1:0]        period;
        logic [PT_WIDTH-1:0]        threshold;
        logic [PT_REPEAT_WIDTH-1:0] repeats;
    } pt_cfg_t;

endpackage

// File: rtl/period_cfg_shadow.sv
// Single-entry holding register for a mid-run period/threshold update; the
// entry is consumed by a load strobe at a period boundary or dropped by clear.
module period_cfg_shadow #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_i,
    input  logic [WIDTH-1:0] period_i,
    input  logic [WIDTH-1:0] threshold_i,
    input  logic             load_i,
    input  logic             clear_i,
    output logic             full_o,
    output logic             full_next_o,
    output logic [WIDTH-1:0] period_o,
    output logic [WIDTH-1:0] threshold_o
);

    logic             full_q, full_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] threshold_q, threshold_d;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no latch is inferred.
        full_d      = full_q;
        period_d    = period_q;
        threshold_d = threshold_q;
        if (clear_i || load_i) begin
            full_d = 1'b0;
        end else if (wr_i && !full_q) begin
            full_d      = 1'b1;
            period_d    = period_i;
            threshold_d = threshold_i;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q      <= 1'b0;
            period_q    <= '0;
            threshold_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            full_q      <= full_d;
            period_q    <= period_d;
            threshold_q <= threshold_d;
        end
    end

    assign full_o      = full_q;
    assign full_next_o = full_d;
    assign period_o    = period_q;
    assign threshold_o = threshold_q;

endmodule

// File: rtl/pulse_period_counter.sv
// Programmable period timer feeding a magnitude comparator (count -> a,
// threshold -> b). Define PULSE_PERIOD_TALLY_EN to add the period_tally output.
module pulse_period_counter
    import pulse_timer_pkg::*;
#(
    parameter int WIDTH        = PT_WIDTH,
    parameter int REPEAT_WIDTH = PT_REPEAT_WIDTH
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [WIDTH-1:0]        cfg_period,
    input  logic [WIDTH-1:0]        cfg_threshold,
    input  logic [REPEAT_WIDTH-1:0] cfg_repeats,
    input  logic                    start,
    input  logic                    abort,
    output logic [WIDTH-1:0]        count,
    output logic [WIDTH-1:0]        threshold,
    output logic                    count_valid,
    output logic                    period_done,
    output logic                    busy,
`ifdef PULSE_PERIOD_TALLY_EN
    output logic [REPEAT_WIDTH-1:0] period_tally,
`endif
    output logic                    done
);

    // The config struct is sized by the package defaults.
    if (WIDTH != PT_WIDTH || REPEAT_WIDTH != PT_REPEAT_WIDTH) begin : g_param_check
        $error("pulse_period_counter: WIDTH/REPEAT_WIDTH must match pulse_timer_pkg");
    end

    pt_state_e               state_q, state_d;
    pt_cfg_t                 act_q, act_d;
    pt_cfg_t                 cfg_in;
    logic [REPEAT_WIDTH-1:0] rep_left_q, rep_left_d;
    logic [WIDTH-1:0]        count_q, count_d;
    logic                    count_valid_q, count_valid_d;
    logic                    period_done_q, period_done_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    cfg_ready_q, cfg_ready_d;
    logic                    xfer;

    logic                    sh_wr, sh_load, sh_clear;
    logic                    sh_full, sh_full_next;
    logic [WIDTH-1:0]        sh_period, sh_threshold;

    // A zero period behaves as a one-cycle period.
    assign cfg_in = '{
        period:    (cfg_period == '0) ? WIDTH'(1) : cfg_period,
        threshold: cfg_threshold,
        repeats:   cfg_repeats
    };

    assign xfer = cfg_valid && cfg_ready_q;

    period_cfg_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clock       (clock),
        .reset_n     (reset_n),
        .wr_i        (sh_wr),
        .period_i    (cfg_in.period),
        .threshold_i (cfg_in.threshold),
        .load_i      (sh_load),
        .clear_i     (sh_clear),
        .full_o      (sh_full),
        .full_next_o (sh_full_next),
        .period_o    (sh_period),
        .threshold_o (sh_threshold)
    );

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        rep_left_d    = rep_left_q;
        count_d       = count_q;
        count_valid_d = count_valid_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        sh_wr         = 1'b0;
        sh_load       = 1'b0;
        sh_clear      = 1'b0;

        if (abort) begin
            // Abort wins over start; a concurrent transfer still lands in the active set.
            sh_clear      = 1'b1;
            count_d       = '0;
            count_valid_d = 1'b0;
            busy_d        = 1'b0;
            if (xfer) begin
                act_d   = cfg_in;
                state_d = ARMED;
            end else begin
                state_d = (state_q == IDLE) ? IDLE : ARMED;
            end
        end else begin
            unique case (state_q)
                IDLE, ARMED: begin
                    if (xfer) begin
                        act_d   = cfg_in;
                        state_d = ARMED;
                    end
                    if (start && state_q == ARMED) begin
                        state_d       = RUN;
                        count_d       = '0;
                        count_valid_d = 1'b1;
                        busy_d        = 1'b1;
                        rep_left_d    = act_d.repeats;
                    end
                end
                RUN: begin
                    sh_wr = xfer;
                    if (period_done_q) begin
                        count_d = '0;
                        if (sh_full) begin
                            sh_load         = 1'b1;
                            act_d.period    = sh_period;
                            act_d.threshold = sh_threshold;
                        end
                        if (act_q.repeats != '0) begin
                            rep_left_d = rep_left_q - 1'b1;
                            if (rep_left_q == REPEAT_WIDTH'(1)) begin
                                state_d       = ARMED;
                                count_valid_d = 1'b0;
                                busy_d        = 1'b0;
                                done_d        = 1'b1;
                            end
                        end
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Registered outputs are derived from the next state so they align with count.
        period_done_d = (state_d == RUN) && (count_d == act_d.period - 1'b1);
        cfg_ready_d   = (state_d != RUN) || !sh_full_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            act_q         <= '0;
            rep_left_q    <= '0;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            period_done_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cfg_ready_q   <= 1'b1;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            rep_left_q    <= rep_left_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            period_done_q <= period_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            cfg_ready_q   <= cfg_ready_d;
        end
    end

`ifdef PULSE_PERIOD_TALLY_EN
    logic [REPEAT_WIDTH-1:0] tally_q;

    // Counts emitted period_done pulses; restarts with each run and saturates.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tally_q <= '0;
        end else if (state_q == ARMED && state_d == RUN) begin
            tally_q <= '0;
        end else if (period_done_q && tally_q != '1) begin
            tally_q <= tally_q + 1'b1;
        end
    end

    assign period_tally = tally_q;
`endif

    assign cfg_ready   = cfg_ready_q;
    assign count       = count_q;
    assign threshold   = act_q.threshold;
    assign count_valid = count_valid_q;
    assign period_done = period_done_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pulse_period_counter.sv
// Self-checking bench for pulse_period_counter: directed scenarios plus random
// stimulus, compared every cycle against a phase/period-level reference model.
module tb_pulse_period_counter;

    localparam int W  = 16;
    localparam int RW = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_period;
    logic [W-1:0]  cfg_threshold;
    logic [RW-1:0] cfg_repeats;
    logic          start;
    logic          abort;
    logic [W-1:0]  count;
    logic [W-1:0]  threshold;
    logic          count_valid;
    logic          period_done;
    logic          busy;
    logic          done;
`ifdef PULSE_PERIOD_TALLY_EN
    logic [RW-1:0] period_tally;
`endif

    always #5 clock = ~clock;

    pulse_period_counter #(.WIDTH(W), .REPEAT_WIDTH(RW)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_period    (cfg_period),
        .cfg_threshold (cfg_threshold),
        .cfg_repeats   (cfg_repeats),
        .start         (start),
        .abort         (abort),
        .count         (count),
        .threshold     (threshold),
        .count_valid   (count_valid),
        .period_done   (period_done),
        .busy          (busy),
`ifdef PULSE_PERIOD_TALLY_EN
        .period_tally  (period_tally),
`endif
        .done          (done)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a run is a sequence of periods, each a phase 0..P-1.
    int m_cfgd, m_run, m_P, m_T, m_R, m_left, m_phase, m_done, m_tally;
    int m_sh_full, m_sh_P, m_sh_T;

    function automatic int exp_count();
        return m_run ? m_phase : 0;
    endfunction
    function automatic int exp_pd();
        return (m_run && m_phase == m_P - 1) ? 1 : 0;
    endfunction
    function automatic int exp_ready();
        return (!m_run || !m_sh_full) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_cfgd = 0; m_run = 0; m_P = 0; m_T = 0; m_R = 0; m_left = 0;
        m_phase = 0; m_done = 0; m_tally = 0; m_sh_full = 0; m_sh_P = 0; m_sh_T = 0;
    endtask

    task automatic model_step(output bit xfer);
        int p_in;
        int was_cfgd;
        xfer = cfg_valid && (exp_ready() != 0);
        p_in = (cfg_period == 0) ? 1 : int'(cfg_period);
        if (exp_pd() != 0 && m_tally < 255) m_tally++;
        m_done = 0;
        if (abort) begin
            if (xfer) begin
                m_P = p_in; m_T = int'(cfg_threshold); m_R = int'(cfg_repeats); m_cfgd = 1;
            end
            m_run = 0; m_phase = 0; m_sh_full = 0;
        end else if (!m_run) begin
            was_cfgd = m_cfgd;
            if (xfer) begin
                m_P = p_in; m_T = int'(cfg_threshold); m_R = int'(cfg_repeats); m_cfgd = 1;
            end
            if (start && was_cfgd != 0) begin
                m_run = 1; m_phase = 0; m_left = m_R; m_tally = 0;
            end
        end else begin
            if (m_phase == m_P - 1) begin
                m_phase = 0;
                if (m_sh_full != 0) begin
                    m_P = m_sh_P; m_T = m_sh_T; m_sh_full = 0;
                end
                if (m_R != 0) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else begin
                m_phase++;
            end
            if (xfer) begin
                m_sh_full = 1; m_sh_P = p_in; m_sh_T = int'(cfg_threshold);
            end
        end
    endtask

    task automatic check_all();
        check("count",       32'(count),       32'(exp_count()));
        check("threshold",   32'(threshold),   32'(m_T));
        check("count_valid", 32'(count_valid), 32'(m_run));
        check("busy",        32'(busy),        32'(m_run));
        check("period_done", 32'(period_done), 32'(exp_pd()));
        check("done",        32'(done),        32'(m_done));
        check("cfg_ready",   32'(cfg_ready),   32'(exp_ready()));
        check("a_lt_b",      32'(count < threshold), 32'(exp_count() < m_T));
`ifdef PULSE_PERIOD_TALLY_EN
        check("period_tally", 32'(period_tally), 32'(m_tally));
`endif
    endtask

    task automatic cycle(output bit xfer);
        @(posedge clock);
        model_step(xfer);
        @(negedge clock);
        check_all();
    endtask

    task automatic step();
        bit x;
        cycle(x);
    endtask

    task automatic idle_inputs();
        cfg_valid = 1'b0; cfg_period = '0; cfg_threshold = '0; cfg_repeats = '0;
        start = 1'b0; abort = 1'b0;
    endtask

    // Offers a configuration and holds it until the model says it transferred.
    task automatic send_cfg(input int p, input int t, input int r);
        bit x;
        int budget = 40;
        cfg_valid = 1'b1; cfg_period = W'(p); cfg_threshold = W'(t); cfg_repeats = RW'(r);
        x = 1'b0;
        while (!x && budget > 0) begin
            cycle(x);
            budget--;
        end
        if (!x) check("cfg_accept_timeout", 0, 1);
        cfg_valid = 1'b0;
    endtask

    task automatic run_until_phase(input int ph);
        int budget = 60;
        while (!(m_run != 0 && m_phase == ph) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("wait_phase_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int n_done;
        int n_lt;
        idle_inputs();
        model_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #11;
        check_all();
        @(negedge clock);
        reset_n = 1'b1;

        // start while IDLE is ignored
        pulse_start();
        step();

        // Period wrap: P=4, thr=2, two periods
        send_cfg(4, 2, 2);
        pulse_start();
        n_done = 0; n_lt = 0;
        for (int i = 0; i < 9; i++) begin
            if (count_valid && count < threshold) n_lt++;
            step();
            n_done += int'(done);
        end
        check("wrap_done_pulses", 32'(n_done), 1);
        check("wrap_a_lt_b_cycles", 32'(n_lt), 4);

        // Mid-run reconfig then backpressure on a continuous P=5 run
        send_cfg(5, 3, 0);
        pulse_start();
        run_until_phase(1);
        send_cfg(3, 1, 7);
        for (int i = 0; i < 8; i++) step();
        send_cfg(6, 4, 0);
        send_cfg(2, 0, 0);
        for (int i = 0; i < 12; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 0);

        // Abort together with start at count 5
        send_cfg(8, 3, 0);
        pulse_start();
        run_until_phase(5);
        abort = 1'b1; start = 1'b1;
        step();
        abort = 1'b0; start = 1'b0;
        check("abort_start_count_valid", 32'(count_valid), 0);
        for (int i = 0; i < 3; i++) step();

        // Zero period with three repeats
        send_cfg(0, 0, 3);
        pulse_start();
        for (int i = 0; i < 5; i++) step();

        // Reset mid-run at count 2
        send_cfg(6, 2, 0);
        pulse_start();
        run_until_phase(2);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        check("reset_busy_immediate", 32'(busy), 0);
        @(negedge clock);
        reset_n = 1'b1;
        pulse_start();
        step();
        check("start_after_reset_ignored", 32'(busy), 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_valid     = ($urandom_range(0, 3) == 0);
            cfg_period    = W'($urandom_range(0, 7));
            cfg_threshold = W'($urandom_range(0, 8));
            cfg_repeats   = RW'($urandom_range(0, 3));
            start         = ($urandom_range(0, 5) == 0);
            abort         = ($urandom_range(0, 49) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
